// File: rtl/matrix_pkg.sv
// Shared definitions for the 2x2 matrix engine and its result collector.
package matrix_pkg;

   // Default element width of the C stream.
   localparam int DEF_DATA_W = 32;

   // Beats per C result burst; the compute stage's output counter uses the same value.
   localparam int C_BEATS = 4;

   // Result collector states.
   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_HOLD    = 2'd2
   } collect_state_t;

endpackage

// File: rtl/c_result_collector_if.sv
// AXI-Stream style C result channel between the matrix engine and the collector.
interface c_result_collector_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/c_result_collector.sv
// Collects a 4-beat 2x2 C result burst, checks tlast framing and holds the
// result in a bank until software clears it. Back-pressures while holding.
module c_result_collector
   import matrix_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int NUM_BEATS = C_BEATS
) (
   input  logic              clk,
   input  logic              rst,
   c_result_collector_if.slave s_axis_c,
   input  logic              clear,
   input  logic [1:0]        rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              result_valid,
   output logic              err_early_last,
   output logic              err_missing_last,
   output logic              irq
);

   localparam logic [1:0] LAST_BEAT = 2'(NUM_BEATS - 1);

   collect_state_t    state_reg, state_next;
   logic [1:0]        beat_cnt_reg;
   logic [DATA_W-1:0] bank_reg [NUM_BEATS];
   logic [DATA_W-1:0] rd_data_reg;
   logic              result_valid_reg;
   logic              err_early_last_reg;
   logic              err_missing_last_reg;
   logic              irq_reg;

   logic hs;
   logic last_beat;
   logic in_collect;
   logic in_drain;
   logic bank_wr;
   logic good_commit;
   logic early_ev;
   logic missing_ev;

   // Handshake and framing decode shared by the FSM and datapath.
   always_comb begin
      hs          = s_axis_c.tvalid && s_axis_c.tready;
      last_beat   = (beat_cnt_reg == LAST_BEAT);
      in_collect  = (state_reg == ST_COLLECT);
      in_drain    = (state_reg == ST_DRAIN);
      // A beat arriving together with clear is dropped from the datapath.
      bank_wr     = in_collect && hs && !clear;
      good_commit = bank_wr && last_beat && s_axis_c.tlast;
      // Framing errors are flagged even when clear coincides, so set wins.
      early_ev    = in_collect && hs && s_axis_c.tlast && !last_beat;
      missing_ev  = in_collect && hs && last_beat && !s_axis_c.tlast;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_COLLECT;
      else     state_reg <= state_next;
   end

   // FSM next-state decode.
   always_comb begin
      state_next = state_reg;
      if (clear) begin
         state_next = ST_COLLECT;
      end else begin
         case (state_reg)
            ST_COLLECT: begin
               if (hs && last_beat) state_next = s_axis_c.tlast ? ST_HOLD : ST_DRAIN;
            end
            ST_DRAIN: begin
               if (hs && s_axis_c.tlast) state_next = ST_COLLECT;
            end
            ST_HOLD:  state_next = ST_HOLD;
            default:  state_next = ST_COLLECT;
         endcase
      end
   end

   // FSM outputs: ready depends only on the registered state.
   always_comb begin
      s_axis_c.tready = (state_reg != ST_HOLD);
   end

   // Beat counter: restarts on clear, on any tlast, and after the final beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt_reg <= '0;
      end else if (clear) begin
         beat_cnt_reg <= '0;
      end else if (in_collect && hs) begin
         if (s_axis_c.tlast || last_beat) beat_cnt_reg <= '0;
         else                            beat_cnt_reg <= beat_cnt_reg + 2'd1;
      end else if (in_drain && hs && s_axis_c.tlast) begin
         beat_cnt_reg <= '0;
      end
   end

   // Result bank, one register per C element, written only while collecting.
   for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_bank
      always_ff @(posedge clk or posedge rst) begin
         if (rst)                                       bank_reg[gi] <= '0;
         else if (bank_wr && beat_cnt_reg == 2'(gi))    bank_reg[gi] <= s_axis_c.tdata;
      end
   end

   // Registered read port, active in every state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data_reg <= '0;
      else     rd_data_reg <= bank_reg[rd_addr];
   end

   // Result status, commit interrupt and sticky framing errors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_valid_reg     <= 1'b0;
         irq_reg              <= 1'b0;
         err_early_last_reg   <= 1'b0;
         err_missing_last_reg <= 1'b0;
      end else begin
         irq_reg <= good_commit;
         if (good_commit)  result_valid_reg <= 1'b1;
         else if (clear)   result_valid_reg <= 1'b0;
         if (early_ev)     err_early_last_reg <= 1'b1;
         else if (clear)   err_early_last_reg <= 1'b0;
         if (missing_ev)   err_missing_last_reg <= 1'b1;
         else if (clear)   err_missing_last_reg <= 1'b0;
      end
   end

   assign rd_data          = rd_data_reg;
   assign result_valid     = result_valid_reg;
   assign err_early_last   = err_early_last_reg;
   assign err_missing_last = err_missing_last_reg;
   assign irq              = irq_reg;

endmodule

// File: tb/tb_c_result_collector.sv
// Directed self-checking bench for the C result collector.
module tb_c_result_collector;
   import matrix_pkg::*;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear = 1'b0;
   logic [1:0]    rd_addr = 2'd0;
   logic [DW-1:0] rd_data;
   logic          result_valid, err_early_last, err_missing_last, irq;

   int n_checks = 0;
   int n_fail   = 0;
   int irq_cnt  = 0;
   int hs_cnt   = 0;
   int irq_base;
   int hs_base;

   c_result_collector_if #(.DATA_W(DW)) c_if ();

   c_result_collector #(.DATA_W(DW), .NUM_BEATS(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .s_axis_c         (c_if.slave),
      .clear            (clear),
      .rd_addr          (rd_addr),
      .rd_data          (rd_data),
      .result_valid     (result_valid),
      .err_early_last   (err_early_last),
      .err_missing_last (err_missing_last),
      .irq              (irq)
   );

   always #5 clk = ~clk;

   // Event monitors: irq pulses and accepted beats.
   always @(posedge clk) begin
      if (irq) irq_cnt++;
      if (!rst && c_if.tvalid && c_if.tready) hs_cnt++;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Send one beat, optionally after idle cycles, waiting (bounded) for ready.
   task automatic send_beat(input logic [31:0] d, input logic last, input int gap);
      int n;
      n = 0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      c_if.tdata  = d;
      c_if.tlast  = last;
      c_if.tvalid = 1'b1;
      while (!c_if.tready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check_val("ready_timeout", 32'(c_if.tready), 32'd1);
      @(posedge clk);
      #1;
      c_if.tvalid = 1'b0;
      c_if.tlast  = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] b0, b1, b2, b3, input int gap);
      send_beat(b0, 1'b0, gap);
      send_beat(b1, 1'b0, gap);
      send_beat(b2, 1'b0, gap);
      send_beat(b3, 1'b1, gap);
   endtask

   task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      @(negedge clk);
      rd_addr = a;
      @(posedge clk);
      #1;
      check_val(tag, rd_data, exp);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   initial begin
      c_if.tdata  = '0;
      c_if.tvalid = 1'b0;
      c_if.tlast  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check_val("rst_tready", 32'(c_if.tready), 32'd1);
      check_val("rst_valid", 32'(result_valid), 32'd0);
      check_val("rst_irq", 32'(irq), 32'd0);
      check_val("rst_errs", {30'd0, err_early_last, err_missing_last}, 32'd0);
      check_val("rst_rd_data", rd_data, 32'd0);

      // Good frame
      irq_base = irq_cnt;
      send_frame(32'h11, 32'h22, 32'h33, 32'h44, 0);
      check_val("good_valid", 32'(result_valid), 32'd1);
      check_val("good_irq_hi", 32'(irq), 32'd1);
      check_val("good_tready", 32'(c_if.tready), 32'd0);
      @(posedge clk);
      #1;
      check_val("good_irq_lo", 32'(irq), 32'd0);
      check_val("good_irq_cnt", 32'(irq_cnt - irq_base), 32'd1);
      read_chk("good_rd0", 2'd0, 32'h11);
      read_chk("good_rd1", 2'd1, 32'h22);
      read_chk("good_rd2", 2'd2, 32'h33);
      read_chk("good_rd3", 2'd3, 32'h44);

      // Backpressure hold
      hs_base = hs_cnt;
      @(negedge clk);
      c_if.tdata  = 32'hFF;
      c_if.tvalid = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      c_if.tvalid = 1'b0;
      check_val("bp_no_hs", 32'(hs_cnt - hs_base), 32'd0);
      read_chk("bp_rd0", 2'd0, 32'h11);
      read_chk("bp_rd3", 2'd3, 32'h44);
      pulse_clear();
      check_val("bp_clr_tready", 32'(c_if.tready), 32'd1);
      check_val("bp_clr_valid", 32'(result_valid), 32'd0);

      // Early tlast
      irq_base = irq_cnt;
      send_beat(32'hA, 1'b0, 0);
      send_beat(32'hB, 1'b1, 0);
      check_val("early_err", 32'(err_early_last), 32'd1);
      check_val("early_valid", 32'(result_valid), 32'd0);
      check_val("early_no_irq", 32'(irq_cnt - irq_base), 32'd0);
      send_frame(32'd1, 32'd2, 32'd3, 32'd4, 0);
      check_val("early_commit", 32'(result_valid), 32'd1);
      read_chk("early_rd0", 2'd0, 32'd1);
      read_chk("early_rd3", 2'd3, 32'd4);
      pulse_clear();
      check_val("early_err_clr", 32'(err_early_last), 32'd0);

      // Missing tlast
      hs_base = hs_cnt;
      send_beat(32'h50, 1'b0, 0);
      send_beat(32'h51, 1'b0, 0);
      send_beat(32'h52, 1'b0, 0);
      send_beat(32'h53, 1'b0, 0);
      check_val("miss_err", 32'(err_missing_last), 32'd1);
      check_val("miss_drain_tready", 32'(c_if.tready), 32'd1);
      send_beat(32'h54, 1'b0, 0);
      send_beat(32'h55, 1'b1, 0);
      check_val("miss_hs_cnt", 32'(hs_cnt - hs_base), 32'd6);
      check_val("miss_valid", 32'(result_valid), 32'd0);
      send_frame(32'h5, 32'h6, 32'h7, 32'h8, 0);
      check_val("miss_commit", 32'(result_valid), 32'd1);
      read_chk("miss_rd0", 2'd0, 32'h5);
      read_chk("miss_rd2", 2'd2, 32'h7);
      pulse_clear();
      check_val("miss_err_clr", 32'(err_missing_last), 32'd0);

      // Stall / valid gaps
      irq_base = irq_cnt;
      send_beat(32'hC0, 1'b0, 2);
      send_beat(32'hC1, 1'b0, 0);
      send_beat(32'hC2, 1'b0, 3);
      send_beat(32'hC3, 1'b1, 1);
      repeat (3) @(posedge clk);
      #1;
      check_val("gap_irq_cnt", 32'(irq_cnt - irq_base), 32'd1);
      read_chk("gap_rd0", 2'd0, 32'hC0);
      read_chk("gap_rd1", 2'd1, 32'hC1);
      read_chk("gap_rd2", 2'd2, 32'hC2);
      read_chk("gap_rd3", 2'd3, 32'hC3);
      pulse_clear();

      // Mid-burst reset
      send_beat(32'hE0, 1'b0, 0);
      send_beat(32'hE1, 1'b0, 0);
      @(negedge clk);
      rst = 1'b1;
      #2;
      check_val("mrst_rd_data", rd_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send_frame(32'h9, 32'hA, 32'hB, 32'hC, 0);
      check_val("mrst_commit", 32'(result_valid), 32'd1);
      check_val("mrst_errs", {30'd0, err_early_last, err_missing_last}, 32'd0);
      read_chk("mrst_rd0", 2'd0, 32'h9);
      read_chk("mrst_rd3", 2'd3, 32'hC);
      pulse_clear();

      // Mid-burst clear
      send_beat(32'hF0, 1'b0, 0);
      send_beat(32'hF1, 1'b0, 0);
      pulse_clear();
      send_frame(32'hD, 32'hE, 32'hF, 32'h10, 0);
      check_val("mclr_commit", 32'(result_valid), 32'd1);
      check_val("mclr_errs", {30'd0, err_early_last, err_missing_last}, 32'd0);
      read_chk("mclr_rd0", 2'd0, 32'hD);
      read_chk("mclr_rd1", 2'd1, 32'hE);
      read_chk("mclr_rd3", 2'd3, 32'h10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
